// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Widths, slot state and port select encodings.
package regfile_arb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_sel_t;

endpackage

// File: rtl/regfile_wr_slot.sv
// One-entry holding slot for a writeback source.
// Ports: clk, reset_n, valid/addr/data in, grant in; ready, current
// and next-state slot contents, capture strobe out. Writes to r0
// are accepted but dropped.
module regfile_wr_slot
  import regfile_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready,
  output logic              capture,
  output logic              full,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data,
  output logic              full_nxt,
  output logic [ADDR_W-1:0] addr_nxt
);

  slot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  always_comb begin
    ready   = reset_n &&
              ((state_q == SLOT_EMPTY) || grant);
    accept  = valid && ready;
    capture = accept && (addr != '0);
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (!reset_n) begin
      state_d = SLOT_EMPTY;
    end else if (capture) begin
      // capture wins over release: grant+accept keeps the slot full
      state_d = SLOT_FULL;
      addr_d  = addr;
      data_d  = data;
    end else if (grant) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign full      = (state_q == SLOT_FULL);
  assign slot_addr = addr_q;
  assign slot_data = data_q;
  assign full_nxt  = (state_d == SLOT_FULL);
  assign addr_nxt  = addr_d;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ports A and B.
// Ports: clk, reset_n; A_/B_ Valid, Addr, Data in, Ready out;
// registered WriteEnable, WriteRegister, WriteData, Busy out.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                A_Valid,
  input  logic [ADDR_W-1:0]   A_Addr,
  input  logic [DATA_W-1:0]   A_Data,
  output logic                A_Ready,
  input  logic                B_Valid,
  input  logic [ADDR_W-1:0]   B_Addr,
  input  logic [DATA_W-1:0]   B_Data,
  output logic                B_Ready,
  output logic                WriteEnable,
  output logic [ADDR_W-1:0]   WriteRegister,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] Busy
);

  logic              grant_a, grant_b;
  logic              a_cap, b_cap;
  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_full_nxt, b_full_nxt;
  logic [ADDR_W-1:0] a_addr_nxt, b_addr_nxt;

  port_sel_t           last_q, last_d;
  port_sel_t           old_q, old_d;
  logic                old_vld_q, old_vld_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  regfile_wr_slot u_slot_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid     (A_Valid),
    .addr      (A_Addr),
    .data      (A_Data),
    .grant     (grant_a),
    .ready     (A_Ready),
    .capture   (a_cap),
    .full      (a_full),
    .slot_addr (a_addr),
    .slot_data (a_data),
    .full_nxt  (a_full_nxt),
    .addr_nxt  (a_addr_nxt)
  );

  regfile_wr_slot u_slot_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid     (B_Valid),
    .addr      (B_Addr),
    .data      (B_Data),
    .grant     (grant_b),
    .ready     (B_Ready),
    .capture   (b_cap),
    .full      (b_full),
    .slot_addr (b_addr),
    .slot_data (b_data),
    .full_nxt  (b_full_nxt),
    .addr_nxt  (b_addr_nxt)
  );

  // Grant sees only slot state, so Ready never depends on Valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (1'b1)
      a_full && !b_full: grant_a = 1'b1;
      !a_full && b_full: grant_b = 1'b1;
      a_full && b_full: begin
        // same target: older write first, ties go to A
        if (a_addr == b_addr)
          grant_a = !old_vld_q || (old_q == PORT_A);
        else
          grant_a = (last_q == PORT_B);
        grant_b = !grant_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    old_d     = old_q;
    old_vld_d = old_vld_q;
    we_d      = grant_a || grant_b;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    busy_d    = '0;
    if (grant_a) begin
      last_d  = PORT_A;
      wreg_d  = a_addr;
      wdata_d = a_data;
    end else if (grant_b) begin
      last_d  = PORT_B;
      wreg_d  = b_addr;
      wdata_d = b_data;
    end
    // age only matters while both slots are occupied
    if (!(a_full_nxt && b_full_nxt)) begin
      old_vld_d = 1'b0;
    end else if (a_full && !grant_a && b_cap) begin
      old_vld_d = 1'b1;
      old_d     = PORT_A;
    end else if (b_full && !grant_b && a_cap) begin
      old_vld_d = 1'b1;
      old_d     = PORT_B;
    end else if (a_cap && b_cap) begin
      old_vld_d = 1'b0;
    end
    if (a_full_nxt) busy_d[a_addr_nxt] = 1'b1;
    if (b_full_nxt) busy_d[b_addr_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q    <= PORT_B;
      old_q     <= PORT_A;
      old_vld_q <= 1'b0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= '0;
    end else begin
      last_q    <= last_d;
      old_q     <= old_d;
      old_vld_q <= old_vld_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign WriteEnable   = we_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter.
// Queue-style reference model plus a negedge-commit register file.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [31:0] busy;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .A_Valid       (a_valid),
    .A_Addr        (a_addr),
    .A_Data        (a_data),
    .A_Ready       (a_ready),
    .B_Valid       (b_valid),
    .B_Addr        (b_addr),
    .B_Data        (b_data),
    .B_Ready       (b_ready),
    .WriteEnable   (we),
    .WriteRegister (wreg),
    .WriteData     (wdata),
    .Busy          (busy)
  );

  logic [31:0] rf [32];
  logic        rf_clr;

  always @(negedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we) begin
      rf[wreg] <= wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  // reference model: per-port pending entry tagged with capture cycle
  bit          m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_seq  [2];
  int          m_last;
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;
  logic [31:0] m_rf [32];
  int          cyc = 0;
  bit          e_ra, e_rb, o_ra, o_rb;

  task automatic step(input bit rst,
                      input bit va, input logic [4:0] aa,
                      input logic [31:0] da,
                      input bit vb, input logic [4:0] ab,
                      input logic [31:0] db);
    int g;
    reset_n = rst;
    a_valid = va; a_addr = aa; a_data = da;
    b_valid = vb; b_addr = ab; b_data = db;
    g = -1;
    if (m_full[0] && m_full[1]) begin
      if (m_addr[0] == m_addr[1])
        g = (m_seq[0] <= m_seq[1]) ? 0 : 1;
      else
        g = (m_last == 1) ? 0 : 1;
    end else if (m_full[0]) begin
      g = 0;
    end else if (m_full[1]) begin
      g = 1;
    end
    e_ra = rst && (!m_full[0] || g == 0);
    e_rb = rst && (!m_full[1] || g == 1);
    #1;
    o_ra = a_ready;
    o_rb = b_ready;
    if (!rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_last = 1; m_we = 0; m_wreg = '0; m_wdata = '0;
    end else begin
      m_we = (g >= 0);
      if (g >= 0) begin
        m_wreg  = m_addr[g];
        m_wdata = m_data[g];
        m_last  = g;
        m_rf[m_wreg] = m_wdata;
        m_full[g] = 0;
      end
      if (va && e_ra && aa != 0) begin
        m_full[0] = 1; m_addr[0] = aa;
        m_data[0] = da; m_seq[0] = cyc;
      end
      if (vb && e_rb && ab != 0) begin
        m_full[1] = 1; m_addr[1] = ab;
        m_data[1] = db; m_seq[1] = cyc;
      end
    end
    m_busy = '0;
    for (int i = 0; i < 2; i++)
      if (m_full[i]) m_busy[m_addr[i]] = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5'd5, 32'h55, 0, 0, 0);
      checks++;
      if (o_ra !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b need 0", o_ra);
      end
      checks++;
      if (we !== 1'b0 || busy !== '0 || wreg !== '0 || wdata !== '0) begin
        errors++;
        $display("FAIL reset_out: got we=%b busy=%h r=%0d d=%h need 0",
                 we, busy, wreg, wdata);
      end
    end
  endtask

  task automatic test_stream();
    logic [4:0]  ad [3];
    logic [31:0] dv [3];
    ad[0] = 5; ad[1] = 6; ad[2] = 7;
    dv[0] = 32'h11; dv[1] = 32'h22; dv[2] = 32'h33;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1, 1, ad[i], dv[i], 0, 0, 0);
      else       step(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (i < 3 && o_ra !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready %0d: got %b need 1", i, o_ra);
      end
      checks++;
      if (we !== m_we || wreg !== m_wreg || wdata !== m_wdata ||
          busy !== m_busy) begin
        errors++;
        $display("FAIL stream_out %0d: got we=%b r=%0d d=%h bz=%h need we=%b r=%0d d=%h bz=%h",
                 i, we, wreg, wdata, busy, m_we, m_wreg, m_wdata, m_busy);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (rf[5] !== 32'h11 || rf[6] !== 32'h22 || rf[7] !== 32'h33) begin
      errors++;
      $display("FAIL stream_rf: got %h %h %h need 11 22 33",
               rf[5], rf[6], rf[7]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(1, 1, 5'd3, 32'hAA + i, 1, 5'd4, 32'hBB + i);
      else       step(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_ra !== e_ra || o_rb !== e_rb) begin
        errors++;
        $display("FAIL cont_ready %0d: got %b%b need %b%b",
                 i, o_ra, o_rb, e_ra, e_rb);
      end
      checks++;
      if (we !== m_we || wreg !== m_wreg || wdata !== m_wdata ||
          busy !== m_busy) begin
        errors++;
        $display("FAIL cont_out %0d: got we=%b r=%0d d=%h bz=%h need we=%b r=%0d d=%h bz=%h",
                 i, we, wreg, wdata, busy, m_we, m_wreg, m_wdata, m_busy);
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (we !== 1'b1 || wreg !== ((i % 2 == 1) ? 5'd3 : 5'd4)) begin
          errors++;
          $display("FAIL cont_alt %0d: got we=%b r=%0d", i, we, wreg);
        end
      end
    end
  endtask

  task automatic test_same_addr();
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd3, 32'h3, 1, 5'd9, 32'h1);
    step(1, 1, 5'd9, 32'h2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (we !== m_we || wreg !== m_wreg || wdata !== m_wdata ||
          busy !== m_busy) begin
        errors++;
        $display("FAIL same_out %0d: got we=%b r=%0d d=%h bz=%h need we=%b r=%0d d=%h bz=%h",
                 i, we, wreg, wdata, busy, m_we, m_wreg, m_wdata, m_busy);
      end
      if (i == 0) begin
        checks++;
        if (busy[9] !== 1'b1) begin
          errors++;
          $display("FAIL same_busy: got %b need 1", busy[9]);
        end
      end
      if (i == 1) begin
        checks++;
        if (we !== 1'b1 || wreg !== 5'd9 || wdata !== 32'h1) begin
          errors++;
          $display("FAIL same_first: got r=%0d d=%h need r=9 d=1",
                   wreg, wdata);
        end
      end
      idle(1);
    end
    @(negedge clk); #1;
    checks++;
    if (rf[9] !== 32'h2) begin
      errors++;
      $display("FAIL same_final: got %h need 2", rf[9]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r0();
    step(1, 1, 5'd0, 32'hDEAD, 0, 0, 0);
    checks++;
    if (o_ra !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready: got %b need 1", o_ra);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (we !== 1'b0 || busy !== '0) begin
        errors++;
        $display("FAIL r0_out %0d: got we=%b bz=%h need 0", i, we, busy);
      end
      idle(1);
    end
    checks++;
    if (rf[0] !== '0) begin
      errors++;
      $display("FAIL r0_rf: got %h need 0", rf[0]);
    end
  endtask

  task automatic test_mid_reset();
    step(1, 1, 5'd11, 32'h5, 1, 5'd12, 32'h6);
    checks++;
    if (busy !== 32'h1800) begin
      errors++;
      $display("FAIL mrst_full: got bz=%h need 1800", busy);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (we !== 1'b0 || busy !== '0) begin
        errors++;
        $display("FAIL mrst_out %0d: got we=%b bz=%h need 0", i, we, busy);
      end
      idle(1);
    end
    checks++;
    if (rf[11] !== '0 || rf[12] !== '0) begin
      errors++;
      $display("FAIL mrst_rf: got %h %h need 0", rf[11], rf[12]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      checks++;
      if (o_ra !== e_ra || o_rb !== e_rb) begin
        errors++;
        $display("FAIL rnd_ready %0d: got %b%b need %b%b",
                 i, o_ra, o_rb, e_ra, e_rb);
      end
      checks++;
      if (we !== m_we || wreg !== m_wreg || wdata !== m_wdata ||
          busy !== m_busy) begin
        errors++;
        $display("FAIL rnd_out %0d: got we=%b r=%0d d=%h bz=%h need we=%b r=%0d d=%h bz=%h",
                 i, we, wreg, wdata, busy, m_we, m_wreg, m_wdata, m_busy);
      end
    end
    idle(4);
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (rf[r] !== m_rf[r]) begin
        errors++;
        $display("FAIL rnd_rf r%0d: got %h need %h", r, rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_full[0] = 0; m_full[1] = 0;
    m_last = 1;
    rf_clr  = 1'b1;
    reset_n = 1'b0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    @(negedge clk); #1;
    rf_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_mid_reset();
    test_contention();
    test_same_addr();
    test_r0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
